// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   - arb_state_e : arbiter FSM states (IDLE, EXEC, RESP)
//   - ALU_W/OP_W  : ALU datapath and opcode widths
//   - ALU_OP_*    : opcode encoding understood by alu64bit
package alu_arb_pkg;

    localparam int ALU_W = 64;
    localparam int OP_W  = 2;

    localparam logic [OP_W-1:0] ALU_OP_ADD = 2'b00;  // s = a + b + cin
    localparam logic [OP_W-1:0] ALU_OP_SUB = 2'b01;  // s = a + ~b + cin (cin=1 for a-b)
    localparam logic [OP_W-1:0] ALU_OP_AND = 2'b10;  // s = a & b, cout = 0
    localparam logic [OP_W-1:0] ALU_OP_XOR = 2'b11;  // s = a ^ b, cout = 0

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_e;

endpackage

// File: rtl/alu64bit.sv
// 64-bit combinational ALU shared by the arbiter clients.
// Ports:
//   a, b  : operands
//   cin   : carry in (used by ADD/SUB)
//   op    : operation, see ALU_OP_* in alu_arb_pkg
//   s     : result
//   cout  : carry out (ADD/SUB only, 0 for logic ops)
module alu64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    input  logic [1:0]  op,
    output logic [63:0] s,
    output logic        cout
);

    logic [64:0] sum_s;
    logic [63:0] b_eff_s;

    // Operand b is inverted for subtraction so both arithmetic ops share one adder.
    always_comb begin
        b_eff_s = (op == 2'b01) ? ~b : b;
        sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {64'd0, cin};
    end

    // Result select.
    always_comb begin
        s    = 64'd0;
        cout = 1'b0;
        case (op)
            2'b00, 2'b01: begin
                s    = sum_s[63:0];
                cout = sum_s[64];
            end
            2'b10: begin
                s    = a & b;
                cout = 1'b0;
            end
            2'b11: begin
                s    = a ^ b;
                cout = 1'b0;
            end
            default: begin
                s    = 64'd0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin picker.
// Ports:
//   req   : request vector
//   ptr   : index with highest priority this round
//   mask  : eligibility mask (all ones when no lock is active)
//   grant : one-hot grant, zero when nothing is eligible
//   idx   : binary index of the granted requester (0 when none)
//   any   : at least one eligible request
module rr_arbiter #(
    parameter int N    = 2,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic [N-1:0]    mask,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [N-1:0] eff_s;
    logic [N-1:0] ge_mask_s;
    logic [N-1:0] cand_hi_s;
    logic [N-1:0] pick_s;

    // Requesters at or above the pointer are preferred; if none of those are
    // eligible the search wraps and the lowest eligible index wins. Isolating
    // the lowest set bit (x & -x) gives the one-hot grant directly.
    always_comb begin
        eff_s = req & mask;
        for (int i = 0; i < N; i++) begin
            ge_mask_s[i] = (ID_W'(i) >= ptr);
        end
        cand_hi_s = eff_s & ge_mask_s;
        pick_s    = (cand_hi_s != {N{1'b0}}) ? cand_hi_s : eff_s;
        grant     = pick_s & (~pick_s + N'(1));
        any       = (eff_s != {N{1'b0}});
    end

    // One-hot to binary conversion of the grant.
    always_comb begin
        idx = {ID_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx = idx | ({ID_W{grant[i]}} & ID_W'(i));
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu64bit between N_REQ requesters.
// One operation in flight: IDLE (arbitrate/accept) -> EXEC (ALU runs on the
// operand registers) -> RESP (hold result until rsp_ready).
// Optional feature macro: ALU_ARB_CHAIN_EN adds req_chain, a lock that keeps
// the grant with one requester and feeds its stored carry into the next op.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester request handshake (ready one-hot)
//   req_a, req_b          : packed 64-bit operands, requester i at [64i+63:64i]
//   req_cin, req_op       : carry in, packed 2-bit opcode
//   req_chain             : chain request (ALU_ARB_CHAIN_EN only)
//   rsp_valid/rsp_ready   : shared response handshake
//   rsp_id, rsp_s, rsp_cout : owner index, ALU result, carry out
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*ALU_W-1:0]     req_a,
    input  logic [N_REQ*ALU_W-1:0]     req_b,
    input  logic [N_REQ-1:0]           req_cin,
    input  logic [N_REQ*OP_W-1:0]      req_op,
`ifdef ALU_ARB_CHAIN_EN
    input  logic [N_REQ-1:0]           req_chain,
`endif
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [ALU_W-1:0]           rsp_s,
    output logic                       rsp_cout
);

    localparam int ID_W = $clog2(N_REQ);

    arb_state_e        state_r, state_s;
    logic [ID_W-1:0]   rr_ptr_r;
    logic [ID_W-1:0]   win_idx_s;
    logic [N_REQ-1:0]  grant_s;
    logic [N_REQ-1:0]  lock_mask_s;
    logic              any_s;
    logic              handshake_s;

    logic [ALU_W-1:0]  a_sel_s, b_sel_s;
    logic [OP_W-1:0]   op_sel_s;
    logic              raw_cin_s, cin_sel_s;

    logic [ALU_W-1:0]  a_r, b_r;
    logic [OP_W-1:0]   op_r;
    logic              cin_r;
    logic [ID_W-1:0]   id_r;

    logic [ALU_W-1:0]  rsp_s_r;
    logic              rsp_cout_r;
    logic [ID_W-1:0]   rsp_id_r;

    logic [ALU_W-1:0]  alu_s_s;
    logic              alu_cout_s;

`ifdef ALU_ARB_CHAIN_EN
    logic              lock_r;
    logic [ID_W-1:0]   lock_id_r;
    logic              carry_r;
    logic              chain_sel_s;
`endif

    // Pointer advance with explicit wrap so non-power-of-two N_REQ works.
    function automatic logic [ID_W-1:0] ptr_next(input logic [ID_W-1:0] p);
        if (p == ID_W'(N_REQ - 1)) begin
            ptr_next = {ID_W{1'b0}};
        end else begin
            ptr_next = p + ID_W'(1);
        end
    endfunction

`ifdef ALU_ARB_CHAIN_EN
    // While locked, only the lock owner is eligible for a grant.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            lock_mask_s[i] = !lock_r || (lock_id_r == ID_W'(i));
        end
    end
`else
    // Without chaining every requester is always eligible.
    always_comb begin
        lock_mask_s = {N_REQ{1'b1}};
    end
`endif

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_r),
        .mask  (lock_mask_s),
        .grant (grant_s),
        .idx   (win_idx_s),
        .any   (any_s)
    );

    // Ready is only offered in IDLE; gating with rst_n keeps it low during reset.
    always_comb begin
        req_ready   = grant_s & {N_REQ{(state_r == IDLE) && rst_n}};
        handshake_s = (state_r == IDLE) && any_s;
    end

    // AND-OR mux of the winner's payload using the one-hot grant.
    always_comb begin
        a_sel_s   = {ALU_W{1'b0}};
        b_sel_s   = {ALU_W{1'b0}};
        op_sel_s  = {OP_W{1'b0}};
        raw_cin_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            a_sel_s   = a_sel_s  | ({ALU_W{grant_s[i]}} & req_a[i*ALU_W +: ALU_W]);
            b_sel_s   = b_sel_s  | ({ALU_W{grant_s[i]}} & req_b[i*ALU_W +: ALU_W]);
            op_sel_s  = op_sel_s | ({OP_W{grant_s[i]}}  & req_op[i*OP_W +: OP_W]);
            raw_cin_s = raw_cin_s | (grant_s[i] & req_cin[i]);
        end
    end

`ifdef ALU_ARB_CHAIN_EN
    // A locked requester continues its chain with the stored carry.
    always_comb begin
        chain_sel_s = |(grant_s & req_chain);
        cin_sel_s   = lock_r ? carry_r : raw_cin_s;
    end
`else
    // Carry in comes straight from the granted requester.
    always_comb begin
        cin_sel_s = raw_cin_s;
    end
`endif

    alu64bit u_alu (
        .a    (a_r),
        .b    (b_r),
        .cin  (cin_r),
        .op   (op_r),
        .s    (alu_s_s),
        .cout (alu_cout_s)
    );

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = handshake_s ? EXEC : IDLE;
            EXEC:    state_s = RESP;
            RESP:    state_s = rsp_ready ? IDLE : RESP;
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, result registers and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= {ALU_W{1'b0}};
            b_r        <= {ALU_W{1'b0}};
            op_r       <= {OP_W{1'b0}};
            cin_r      <= 1'b0;
            id_r       <= {ID_W{1'b0}};
            rsp_s_r    <= {ALU_W{1'b0}};
            rsp_cout_r <= 1'b0;
            rsp_id_r   <= {ID_W{1'b0}};
            rr_ptr_r   <= {ID_W{1'b0}};
        end else begin
            if (handshake_s) begin
                a_r   <= a_sel_s;
                b_r   <= b_sel_s;
                op_r  <= op_sel_s;
                cin_r <= cin_sel_s;
                id_r  <= win_idx_s;
            end
            if (state_r == EXEC) begin
                rsp_s_r    <= alu_s_s;
                rsp_cout_r <= alu_cout_s;
                rsp_id_r   <= id_r;
            end
            if ((state_r == RESP) && rsp_ready) begin
                rr_ptr_r <= ptr_next(rsp_id_r);
            end
        end
    end

`ifdef ALU_ARB_CHAIN_EN
    // Lock follows the chain bit of each accepted op; a chain=0 op releases it.
    // Arbitration only happens in IDLE, so releasing at accept is equivalent
    // to releasing after that op completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_r    <= 1'b0;
            lock_id_r <= {ID_W{1'b0}};
            carry_r   <= 1'b0;
        end else begin
            if (handshake_s) begin
                lock_r    <= chain_sel_s;
                lock_id_r <= win_idx_s;
            end
            if (state_r == EXEC) begin
                carry_r <= alu_cout_s;
            end
        end
    end
`endif

    // Response outputs come straight from registers.
    always_comb begin
        rsp_valid = (state_r == RESP);
        rsp_s     = rsp_s_r;
        rsp_cout  = rsp_cout_r;
        rsp_id    = rsp_id_r;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (N_REQ = 2).
// Inputs are driven just after the falling edge; outputs are sampled 1 time
// unit later, well away from the rising edge.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int N = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*64-1:0]    req_a;
    logic [N*64-1:0]    req_b;
    logic [N-1:0]       req_cin;
    logic [N*2-1:0]     req_op;
`ifdef ALU_ARB_CHAIN_EN
    logic [N-1:0]       req_chain;
`endif
    logic               rsp_valid;
    logic               rsp_ready;
    logic [0:0]         rsp_id;
    logic [63:0]        rsp_s;
    logic               rsp_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_op    (req_op),
`ifdef ALU_ARB_CHAIN_EN
        .req_chain (req_chain),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_cout  (rsp_cout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input logic [1:0] op);
        req_a[i*64 +: 64] = a;
        req_b[i*64 +: 64] = b;
        req_cin[i]        = cin;
        req_op[i*2 +: 2]  = op;
    endtask

    // One isolated operation from requester i, starting in IDLE right after a falling edge.
    task automatic run_single(input int i, input logic [63:0] a, input logic [63:0] b,
                              input logic cin, input logic [1:0] op,
                              input logic [63:0] exp_s, input logic exp_cout, input string tag);
        logic [N-1:0] onehot;
        onehot    = '0;
        onehot[i] = 1'b1;
        set_req(i, a, b, cin, op);
        req_valid = onehot;
        rsp_ready = 1'b0;
        #1;
        chk({tag, "_ready"}, 64'(req_ready), 64'(onehot));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk({tag, "_exec_valid"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        #1;
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_s"},     rsp_s,          exp_s);
        chk({tag, "_cout"},  64'(rsp_cout),  64'(exp_cout));
        chk({tag, "_id"},    64'(rsp_id),    64'(i));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [N-1:0] exp_gnt;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
`ifdef ALU_ARB_CHAIN_EN
        req_chain = '0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_s",     rsp_s,          64'd0);
        chk("rst_rsp_cout",  64'(rsp_cout),  64'd0);
        chk("rst_rsp_id",    64'(rsp_id),    64'd0);
        @(negedge clk);

        // Basic ops; requester 0 three times leaves rr_ptr at 1, then requester 1 returns it to 0.
        run_single(0, 64'd5, 64'd3, 1'b0, ALU_OP_ADD, 64'd8, 1'b0, "add");
        run_single(0, 64'hF0F0, 64'hFF00, 1'b0, ALU_OP_AND, 64'hF000, 1'b0, "and");
        run_single(0, 64'hF0F0, 64'hFF00, 1'b0, ALU_OP_XOR, 64'h0FF0, 1'b0, "xor");
        run_single(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, ALU_OP_ADD, 64'd0, 1'b1, "carry");

        // Both requesters valid continuously: grants alternate, one op per 3 cycles.
        set_req(0, 64'd10, 64'd1, 1'b0, ALU_OP_ADD);  // 11, cout 0
        set_req(1, 64'd20, 64'd2, 1'b1, ALU_OP_SUB);  // 18, cout 1 (no borrow)
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("rr_grant", 64'(req_ready), 64'(exp_gnt));
            @(negedge clk); #1;
            chk("rr_exec_valid", 64'(rsp_valid), 64'd0);
            @(negedge clk); #1;
            chk("rr_valid", 64'(rsp_valid), 64'd1);
            chk("rr_id",    64'(rsp_id),    64'(k % 2));
            chk("rr_s",     rsp_s,          (k % 2 == 0) ? 64'd11 : 64'd18);
            chk("rr_cout",  64'(rsp_cout),  (k % 2 == 0) ? 64'd0 : 64'd1);
            @(negedge clk); #1;
        end
        req_valid = '0;
        rsp_ready = 1'b0;

        // Backpressure: rsp_ready low for 5 RESP cycles while requester 1 waits.
        set_req(0, 64'hF0F0, 64'hFF00, 1'b0, ALU_OP_AND);
        set_req(1, 64'hF0F0, 64'hFF00, 1'b0, ALU_OP_XOR);
        req_valid = 2'b01;
        #1;
        chk("bp_grant0", 64'(req_ready), 64'd1);
        @(negedge clk); #1;
        req_valid = 2'b10;
        #1;
        chk("bp_exec_ready", 64'(req_ready), 64'd0);
        @(negedge clk); #1;
        for (int j = 0; j < 5; j++) begin
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_s",     rsp_s,          64'hF000);
            chk("bp_cout",  64'(rsp_cout),  64'd0);
            chk("bp_id",    64'(rsp_id),    64'd0);
            chk("bp_ready", 64'(req_ready), 64'd0);
            if (j < 4) begin
                @(negedge clk); #1;
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_next_grant", 64'(req_ready), 64'd2);
        chk("bp_idle_valid", 64'(rsp_valid), 64'd0);

        // Reset during EXEC of requester 1's op; rr_ptr is 1 at this point.
        req_valid = 2'b11;
        @(negedge clk); #1;
        chk("rm_exec_valid", 64'(rsp_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rm_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rm_rsp_s",     rsp_s,          64'd0);
        chk("rm_rsp_cout",  64'(rsp_cout),  64'd0);
        chk("rm_rsp_id",    64'(rsp_id),    64'd0);
        chk("rm_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rm_first_grant", 64'(req_ready), 64'd1);
        req_valid = 2'b01;
        @(negedge clk); #1;
        req_valid = '0;
        chk("rm_no_stale_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clk); #1;
        chk("rm_valid", 64'(rsp_valid), 64'd1);
        chk("rm_id",    64'(rsp_id),    64'd0);
        chk("rm_s",     rsp_s,          64'hF000);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;

`ifdef ALU_ARB_CHAIN_EN
        // 128-bit add as two chained words from requester 0; rr_ptr is 1 here.
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, ALU_OP_ADD);
        req_chain = 2'b01;
        req_valid = 2'b01;
        #1;
        chk("ch_lo_grant", 64'(req_ready), 64'd1);
        @(negedge clk); #1;
        set_req(0, 64'd0, 64'd0, 1'b0, ALU_OP_ADD);
        set_req(1, 64'd7, 64'd8, 1'b0, ALU_OP_ADD);
        req_chain = 2'b00;
        req_valid = 2'b11;
        @(negedge clk); #1;
        chk("ch_lo_s",    rsp_s,         64'd0);
        chk("ch_lo_cout", 64'(rsp_cout), 64'd1);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("ch_locked_grant", 64'(req_ready), 64'd1);
        @(negedge clk); #1;
        req_valid = 2'b10;
        @(negedge clk); #1;
        chk("ch_hi_s",  rsp_s,       64'd1);
        chk("ch_hi_id", 64'(rsp_id), 64'd0);
        @(negedge clk); #1;
        chk("ch_next_grant", 64'(req_ready), 64'd2);
        @(negedge clk); #1;
        req_valid = '0;
        @(negedge clk); #1;
        chk("ch_req1_s",  rsp_s,       64'd15);
        chk("ch_req1_id", 64'(rsp_id), 64'd1);
        @(negedge clk);
        rsp_ready = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares one `alu64bit` instance between `N_REQ` requesters. Each requester issues single ALU operations (a, b, cin, op) over a valid/ready request channel. The block registers the operands, runs them through the ALU, and returns s/cout with the requester ID on one shared valid/ready response channel. It sits between the datapath clients and the ALU, so no client drives the ALU directly.

## Interface
- `N_REQ`, default 2, number of requesters; legal 2..4.
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `req_valid` input, N_REQ: request valid, one bit per requester.
- `req_ready` output, N_REQ: request accepted, one-hot or zero.
- `req_a` input, N_REQ*64: operand a; requester i occupies [64i+63:64i].
- `req_b` input, N_REQ*64: operand b, same packing as `req_a`.
- `req_cin` input, N_REQ: carry in.
- `req_op` input, N_REQ*2: ALU op; requester i occupies [2i+1:2i].
- `req_chain` input, N_REQ: chain request. Present only with `ALU_ARB_CHAIN_EN`.
- `rsp_valid` output, 1: response valid.
- `rsp_ready` input, 1: response consumed.
- `rsp_id` output, $clog2(N_REQ): index of the requester that owns the response.
- `rsp_s` output, 64: ALU result.
- `rsp_cout` output, 1: ALU carry out.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Arbitrate among the asserted `req_valid` bits. Search starts at the round-robin pointer `rr_ptr`.
  - `req_ready[w]` is driven combinationally high only for the winner w.
  - On handshake: latch a, b, cin, op and w; go to EXEC.
  - With no `req_valid` asserted, stay in IDLE and keep all `req_ready` low.
- **EXEC**
  - The ALU inputs come from the operand registers.
  - At the clock edge, register s and cout into `rsp_s`/`rsp_cout`, set `rsp_id`=w, and go to RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_s`, `rsp_cout` and `rsp_id` are held stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`: go to IDLE and set `rr_ptr` = (w+1) mod N_REQ.
  - `req_ready` stays low while the block is in EXEC or RESP.
- Only one operation is in flight at a time. Requests are never dropped or reordered per requester.
- Requester payload must stay stable while its `req_valid` is high. A requester may deassert `req_valid` before it is granted.
- Reset values:
  - state=IDLE, `rr_ptr`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_s`=0, `rsp_cout`=0, `rsp_id`=0.
  - Operand registers =0. Chain lock and stored carry cleared.
- Reset asserted mid-operation aborts the operation and discards the result. No response is issued for it.

## Timing
- Latency: request handshake in cycle T; `rsp_valid` high from cycle T+2.
- Peak throughput: one operation per 3 cycles, reached when `rsp_ready` is held high.
- Backpressure: each cycle of low `rsp_ready` in RESP adds one cycle of delay. Nothing is lost.
- Fairness: a requester that keeps `req_valid` high is granted within N_REQ arbitration rounds.
- Simultaneous requests: the winner is the lowest index ≥ `rr_ptr`, wrapping past N_REQ-1 to 0.

## Configuration
- **`ALU_ARB_CHAIN_EN` defined**
  - Adds the `req_chain` port, a lock flag and a stored-carry register.
  - Accepting an op with chain=1 sets lock to the winner. The stored carry takes `rsp_cout` when the op leaves EXEC.
  - While locked, only the locked requester can be granted, and its next op uses cin = stored carry (ignores `req_cin`).
  - Accepting an op with chain=0 clears the lock after that op. `rr_ptr` is then updated normally.
  - Purpose: multi-word add/sub (e.g. a 128-bit add as two 64-bit ops) without interleaving from other requesters.
- **`ALU_ARB_CHAIN_EN` undefined**
  - No `req_chain` port and no lock logic.
  - cin is always taken from `req_cin`.

## Structure
- Package `alu_arb_pkg` holds:
  - the state enum (IDLE/EXEC/RESP),
  - `ALU_W`=64 and `OP_W`=2,
  - named op constants `ALU_OP_*` matching the `alu64bit` op encoding.
- Sub-module `rr_arbiter`: a combinational N-way round-robin picker. Inputs are the request vector, `rr_ptr` and an optional lock mask; outputs are a one-hot grant and the binary winner index.
- The block instantiates the existing `alu64bit` unchanged.

## Test plan
- **Single request:** req0 a=5, b=3, cin=0, op=`ALU_OP_ADD` → `rsp_valid` 2 cycles after the handshake; `rsp_s`=8, `rsp_cout`=0, `rsp_id`=0.
- **Carry out:** req1 a=64'hFFFF_FFFF_FFFF_FFFF, b=1, ADD → `rsp_s`=0, `rsp_cout`=1, `rsp_id`=1.
- **Simultaneous and fairness:** both requesters valid continuously from reset → grants alternate 0,1,0,1. Four responses arrive with `rsp_id` 0,1,0,1.
- **Backpressure:** `rsp_ready` held low 5 cycles in RESP →
  - outputs stay stable,
  - `req_ready` stays 0,
  - the next grant occurs the cycle after the handshake.
- **Reset mid-op:** `rst_n` pulsed low during EXEC → all outputs return to 0 immediately. After release, the first grant goes to requester 0.
- **Chain (with `ALU_ARB_CHAIN_EN`):** req0 sends lo word (a=all-ones, b=1, chain=1), then hi word (a=0, b=0, chain=0, `req_cin`=0), while req1 is also valid →
  - req1 is not granted between the two words,
  - the hi-word response is `rsp_s`=1 (carry chained),
  - req1 is served next.
